// File: rtl/demux_stream_if.sv
// Stream bus for demux_stream: one tagged input stream fanned out to NUM_CH
// independent valid/ready output channels.
interface demux_stream_if #(
  parameter int NUM_CH = 31,
  parameter int DW     = 2,
  parameter int SELW   = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [SELW-1:0]      in_sel;
  logic [DW-1:0]        in_data;
  logic [NUM_CH-1:0]    out_valid;
  logic [NUM_CH-1:0]    out_ready;
  logic [NUM_CH*DW-1:0] out_data;

  // master: the environment (input source plus per-channel consumers)
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // slave: the demultiplexer itself
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_stream.sv
// Registered 1-to-NUM_CH stream demultiplexer with a one-entry buffer per
// channel; out-of-range select codes are accepted, discarded and counted.
module demux_stream #(
  parameter int NUM_CH = 31,
  parameter int DW     = 2,
  parameter int SELW   = 5,
  parameter int CNTW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  demux_stream_if.slave   s,
  output logic [CNTW-1:0] drop_cnt,
  output logic            busy
);
  localparam int SELN = 2**SELW;

  logic [NUM_CH-1:0] valid_reg;
  logic [DW-1:0]     data_reg [NUM_CH];
  logic [CNTW-1:0]   drop_reg;
  logic [SELN-1:0]   valid_ext;
  logic [SELN-1:0]   ready_ext;
  logic              sel_legal;
  logic              in_fire;

  // Widen to the full select range so drop codes index a defined (zero) bit.
  assign valid_ext = SELN'(valid_reg);
  assign ready_ext = SELN'(s.out_ready);
  assign sel_legal = {{(32-SELW){1'b0}}, s.in_sel} < 32'(NUM_CH);

  // Pass-through on drain: a full channel whose consumer is ready takes a new word.
  assign s.in_ready = !reset &&
                      (!sel_legal || !valid_ext[s.in_sel] || ready_ext[s.in_sel]);
  assign in_fire    = s.in_valid && s.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
      drop_reg  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_fire && sel_legal && (s.in_sel == SELW'(i))) begin
          valid_reg[i] <= 1'b1;
          data_reg[i]  <= s.in_data;
        end else if (s.out_ready[i]) begin
          valid_reg[i] <= 1'b0;
        end
      end
      if (in_fire && !sel_legal && (drop_reg != {CNTW{1'b1}})) begin
        drop_reg <= drop_reg + CNTW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
    assign s.out_data[gi*DW +: DW] = data_reg[gi];
  end

  assign s.out_valid = valid_reg;
  assign drop_cnt    = drop_reg;
  assign busy        = |valid_reg;
endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream: stimulus pushes expected words per channel,
// a negedge monitor pops them on every output handshake.
module tb_demux_stream;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] drop_cnt;
  logic       busy;
  logic [1:0] drop_cnt2;
  logic       busy2;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q [31][$];
  logic [1:0] mon_e;

  demux_stream_if #(.NUM_CH(31), .DW(2), .SELW(5)) b  ();
  demux_stream_if #(.NUM_CH(31), .DW(2), .SELW(5)) b2 ();

  demux_stream #(.NUM_CH(31), .DW(2), .SELW(5), .CNTW(8)) u_dut (
    .clk(clk), .reset(reset), .s(b.slave), .drop_cnt(drop_cnt), .busy(busy)
  );

  demux_stream #(.NUM_CH(31), .DW(2), .SELW(5), .CNTW(2)) u_sat (
    .clk(clk), .reset(reset), .s(b2.slave), .drop_cnt(drop_cnt2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one word, wait (bounded) for in_ready, transfer, then check 1-cycle latency.
  task automatic send(input int sel, input logic [1:0] d, input bit exp_rdy, input bit push);
    int n = 0;
    b.in_valid = 1'b1;
    b.in_sel   = 5'(sel);
    b.in_data  = d;
    @(negedge clk);
    if (exp_rdy) chk($sformatf("in_ready_sel%0d", sel), 64'(b.in_ready), 64'd1);
    while (!b.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b.in_ready) begin
      chk($sformatf("send_timeout_sel%0d", sel), 64'(b.in_ready), 64'd1);
      b.in_valid = 1'b0;
    end else begin
      if (push && sel < 31) exp_q[sel].push_back(d);
      @(posedge clk);
      #1;
      b.in_valid = 1'b0;
      if (sel < 31) begin
        chk($sformatf("latency_valid_ch%0d", sel), 64'(b.out_valid[sel]), 64'd1);
        chk($sformatf("latency_data_ch%0d", sel), 64'(b.out_data[sel*2 +: 2]), 64'(d));
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < 31; i++) begin
          if (b.out_valid[i] && b.out_ready[i]) begin
            if (exp_q[i].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out_ch%0d: got data %0h, expected no transfer",
                       i, b.out_data[i*2 +: 2]);
            end else begin
              mon_e = exp_q[i].pop_front();
              chk($sformatf("out_ch%0d", i), 64'(b.out_data[i*2 +: 2]), 64'(mon_e));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset       = 1'b1;
    b.in_valid  = 1'b0;
    b.in_sel    = '0;
    b.in_data   = '0;
    b.out_ready = '0;
    b2.in_valid  = 1'b0;
    b2.in_sel    = '0;
    b2.in_data   = '0;
    b2.out_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(b.in_ready), 64'd0);
    chk("reset_out_valid", 64'(b.out_valid), 64'd0);
    chk("reset_out_data", 64'(b.out_data), 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // 1: every channel in turn with consumers always ready
    b.out_ready = '1;
    for (int s = 0; s < 31; s++) send(s, 2'(s % 4), 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_drained", 64'(b.out_valid), 64'd0);
    chk("t1_drop_cnt", 64'(drop_cnt), 64'd0);

    // 2: back-pressure on channel 12, then pass-through replacement
    b.out_ready[12] = 1'b0;
    send(12, 2'b10, 1'b1, 1'b1);
    fork
      send(12, 2'b01, 1'b0, 1'b1);
      begin
        repeat (3) @(negedge clk);
        chk("t2_in_ready_blocked", 64'(b.in_ready), 64'd0);
        chk("t2_hold_valid", 64'(b.out_valid[12]), 64'd1);
        chk("t2_hold_data", 64'(b.out_data[12*2 +: 2]), 64'(2'b10));
        @(posedge clk);
        #1;
        b.out_ready[12] = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("t2_drained", 64'(b.out_valid), 64'd0);

    // 3: adjacent channels 12 and 13 held with no consumer
    b.out_ready = '0;
    send(12, 2'b11, 1'b1, 1'b1);
    send(13, 2'b00, 1'b1, 1'b1);
    chk("t3_valid_bits", 64'(b.out_valid), 64'h3000);
    chk("t3_data12", 64'(b.out_data[12*2 +: 2]), 64'(2'b11));
    chk("t3_data13", 64'(b.out_data[13*2 +: 2]), 64'(2'b00));
    chk("t3_busy", 64'(busy), 64'd1);

    // 4: drop codes, then the top legal channel
    for (int k = 1; k <= 3; k++) begin
      send(31, 2'(k), 1'b1, 1'b1);
      chk($sformatf("t4_valid_after_drop%0d", k), 64'(b.out_valid), 64'h3000);
    end
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd3);
    send(30, 2'b01, 1'b1, 1'b1);
    chk("t4_valid_bits", 64'(b.out_valid), 64'h4000_3000);
    b.out_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("t4_drained", 64'(b.out_valid), 64'd0);
    chk("t4_busy_idle", 64'(busy), 64'd0);

    // 5: 2-bit drop counter saturates at 3
    b2.in_valid = 1'b1;
    b2.in_sel   = 5'd31;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("t5_in_ready%0d", k), 64'(b2.in_ready), 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("t5_drop_cnt%0d", k), 64'(drop_cnt2), 64'(k < 3 ? k : 3));
    end
    b2.in_valid = 1'b0;
    chk("t5_no_valid", 64'(b2.out_valid), 64'd0);

    // 6: reset with words buffered and a handshake offered
    b.out_ready = '0;
    send(5, 2'b11, 1'b1, 1'b0);
    send(20, 2'b10, 1'b1, 1'b0);
    chk("t6_filled", 64'(b.out_valid), 64'h0010_0020);
    b.in_valid = 1'b1;
    b.in_sel   = 5'd7;
    b.in_data  = 2'b01;
    reset      = 1'b1;
    #1;
    chk("t6_in_ready_in_reset", 64'(b.in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    b.in_valid = 1'b0;
    chk("t6_out_valid", 64'(b.out_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("t6_sat_drop_cnt", 64'(drop_cnt2), 64'd0);
    b.out_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_still_idle", 64'(b.out_valid), 64'd0);

    for (int i = 0; i < 31; i++) begin
      if (exp_q[i].size() != 0)
        chk($sformatf("leftover_ch%0d", i), 64'(exp_q[i].size()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Registered 1-to-31 demultiplexer; the inverse of the team's 31:1 2-bit select mux.
- Accepts one 2-bit data word per handshake, tagged with a 5-bit destination select.
- Routes the word into a one-entry holding buffer for that output channel, each channel with its own valid/ready handshake.
- Select code 31 (no channel) is accepted and discarded, and counted.

Parameters:
- NUM_CH, 31, number of output channels; sel values 0..NUM_CH-1 are legal, NUM_CH..31 are drop codes.
- DW, 2, data word width.
- SELW, 5, select width; must satisfy 2**SELW > NUM_CH.
- CNTW, 8, width of the drop counter.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can take the input word this cycle.
- in_sel  input  SELW  destination channel.
- in_data  input  DW  data word.
- out_valid  output  NUM_CH  per-channel buffer full; bit i belongs to channel i.
- out_ready  input  NUM_CH  per-channel consumer ready.
- out_data  output  NUM_CH*DW  channel i data at bits [i*DW +: DW].
- drop_cnt  output  CNTW  count of accepted drop-code words; saturates.
- busy  output  1  OR of all out_valid bits.

Behaviour:
- Reset, synchronous, active-high (clk, reset):
  - out_valid = 0, out_data = 0, drop_cnt = 0, busy = 0.
  - in_ready is forced to 0 during any cycle in which reset is high.
  - Reset mid-transfer discards all buffered words without producing any output handshake.
- Handshakes:
  - Input transfer: in_valid & in_ready at the rising edge.
  - Output transfer on channel i: out_valid[i] & out_ready[i].
- in_ready is combinational. Outside reset:
  - If in_sel < NUM_CH: in_ready = !out_valid[in_sel] | out_ready[in_sel]. This is pass-through on drain, so a full channel whose consumer is ready accepts a new word in the same cycle.
  - If in_sel >= NUM_CH: in_ready = 1.
  - in_ready must not depend on in_valid.
- Legal select, input transfer:
  - Next cycle: out_valid[in_sel] = 1 and channel in_sel data = in_data.
  - Latency is exactly 1 cycle from input transfer to out_valid.
- Output transfer on channel i with no new input to i: out_valid[i] clears next cycle. out_data for that channel holds its last value; it is don't-care while invalid.
- Output transfer and input transfer to the same channel in the same cycle: out_valid[i] stays 1 and the data is replaced by the new word. No bubble, no loss.
- Only the channel addressed by in_sel is written. All other channel buffers hold their state, apart from their own output drains.
- Drop code with input transfer:
  - Word discarded; drop_cnt += 1, saturating at 2**CNTW-1.
  - No out_valid change.
- Data stability: out_data[i] and out_valid[i] must not change while out_valid[i]=1 and out_ready[i]=0.
- Input rule: in_sel and in_data may change freely while in_valid=0. While in_valid=1 and in_ready=0, the source holds them; the block does not check this.
- busy = |out_valid. It is registered-derived, with no combinational path from the inputs.
- No internal FSM beyond the per-channel two-state buffer: EMPTY -> FULL on write; FULL -> EMPTY on drain without write; FULL -> FULL on drain with write.

Test Plan:
1. Reset, then hold out_ready = all 1s. Send sel 0..30 with data = sel[1:0] on consecutive cycles. -> Each out_valid[i] pulses one cycle, exactly 1 cycle after its input, carrying data i%4. drop_cnt = 0. in_ready stays 1 throughout.
2. out_ready[12] = 0. Send sel 12 data 2'b10, then sel 12 data 2'b01. -> The first is accepted; in_ready = 0 for the second while sel = 12. Channel 12 holds 2'b10 and out_valid[12] stays 1. Raise out_ready[12] -> the second word is accepted in that same cycle, and channel 12 shows 2'b01 next cycle.
3. Send sel 12 data 2'b11, then sel 13 data 2'b00, with out_ready = 0. -> Only bit 12 and bit 13 are set, with their own data. Confirms 12 and 13 do not alias.
4. Send sel 31 three times, then sel 30 data 2'b01. -> drop_cnt = 3 and no out_valid bit rises for the sel 31 words. Channel 30 is valid with 2'b01.
5. With CNTW = 2, send sel 31 six times. -> drop_cnt goes 1, 2, 3, 3, 3, 3 (saturates at 3).
6. Fill channels 5 and 20 with out_ready = 0, then assert reset for one cycle during an input handshake. -> After reset: out_valid = 0, busy = 0, drop_cnt = 0, and in_ready was 0 during the reset cycle.
